// File: rtl/wb_arbiter2_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master ports and the
// shared slave port. The arbiter uses the slave view; the environment that
// drives masters and models the slave uses the master view.
interface wb_arbiter2_if;
    logic [63:0] i_m0_adr;
    logic [63:0] i_m0_dat;
    logic        i_m0_we;
    logic [7:0]  i_m0_sel;
    logic        i_m0_stb;
    logic        i_m0_cyc;
    logic [63:0] o_m0_dat;
    logic        o_m0_ack;
    logic        o_m0_stall;
    logic        o_m0_err;

    logic [63:0] i_m1_adr;
    logic [63:0] i_m1_dat;
    logic        i_m1_we;
    logic [7:0]  i_m1_sel;
    logic        i_m1_stb;
    logic        i_m1_cyc;
    logic [63:0] o_m1_dat;
    logic        o_m1_ack;
    logic        o_m1_stall;
    logic        o_m1_err;

    logic [63:0] o_wb_adr;
    logic [63:0] o_wb_dat;
    logic        o_wb_we;
    logic [7:0]  o_wb_sel;
    logic        o_wb_stb;
    logic        o_wb_cyc;
    logic [63:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_stall;

    modport slave (
        input  i_m0_adr, i_m0_dat, i_m0_we, i_m0_sel, i_m0_stb, i_m0_cyc,
        output o_m0_dat, o_m0_ack, o_m0_stall, o_m0_err,
        input  i_m1_adr, i_m1_dat, i_m1_we, i_m1_sel, i_m1_stb, i_m1_cyc,
        output o_m1_dat, o_m1_ack, o_m1_stall, o_m1_err,
        output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        input  i_wb_dat, i_wb_ack, i_wb_stall
    );

    modport master (
        output i_m0_adr, i_m0_dat, i_m0_we, i_m0_sel, i_m0_stb, i_m0_cyc,
        input  o_m0_dat, o_m0_ack, o_m0_stall, o_m0_err,
        output i_m1_adr, i_m1_dat, i_m1_we, i_m1_sel, i_m1_stb, i_m1_cyc,
        input  o_m1_dat, o_m1_ack, o_m1_stall, o_m1_err,
        input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        output i_wb_dat, i_wb_ack, i_wb_stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (m0 = instruction fetch, m1 = load/store).
// Non-preemptive ownership, round-robin on ties, zero-bubble handover, and a
// per-cycle no-ack timeout that aborts the cycle and locks the offending
// master out until it drops cyc.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    wb_arbiter2_if.slave     bus,
    output logic [1:0]       o_grant
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_cnt_nx;
    logic        lock0;
    logic        lock1;
    logic        last_m1;     // 1 when m1 was the most recent grant
    logic        req0;
    logic        req1;
    logic        tmo0;
    logic        tmo1;

    // A master competes only when requesting and not locked out
    always_comb begin
        req0 = bus.i_m0_cyc & ~lock0;
        req1 = bus.i_m1_cyc & ~lock1;
    end

    // Next-state selection and bus/master output muxing
    always_comb begin
        state_nx       = state;
        tmo0           = 1'b0;
        tmo1           = 1'b0;
        bus.o_wb_adr   = '0;
        bus.o_wb_dat   = '0;
        bus.o_wb_we    = 1'b0;
        bus.o_wb_sel   = '0;
        bus.o_wb_stb   = 1'b0;
        bus.o_wb_cyc   = 1'b0;
        bus.o_m0_dat   = '0;
        bus.o_m0_ack   = 1'b0;
        bus.o_m0_stall = 1'b1;
        bus.o_m0_err   = 1'b0;
        bus.o_m1_dat   = '0;
        bus.o_m1_ack   = 1'b0;
        bus.o_m1_stall = 1'b1;
        bus.o_m1_err   = 1'b0;

        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_m1)) begin
                    state_nx = OWN0;
                end else if (req1) begin
                    state_nx = OWN1;
                end
            end
            OWN0: begin
                // A simultaneous ack beats the timeout
                tmo0           = bus.i_m0_cyc && !bus.i_wb_ack && (tmo_cnt >= TMO_LIMIT);
                bus.o_wb_adr   = bus.i_m0_adr;
                bus.o_wb_dat   = bus.i_m0_dat;
                bus.o_wb_we    = bus.i_m0_we;
                bus.o_wb_sel   = bus.i_m0_sel;
                bus.o_wb_stb   = bus.i_m0_stb & ~tmo0;
                bus.o_wb_cyc   = bus.i_m0_cyc & ~tmo0;
                bus.o_m0_dat   = bus.i_wb_dat;
                bus.o_m0_ack   = bus.i_wb_ack;
                bus.o_m0_stall = bus.i_wb_stall;
                bus.o_m0_err   = tmo0;
                if (tmo0) begin
                    state_nx = IDLE;
                end else if (!bus.i_m0_cyc) begin
                    state_nx = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                tmo1           = bus.i_m1_cyc && !bus.i_wb_ack && (tmo_cnt >= TMO_LIMIT);
                bus.o_wb_adr   = bus.i_m1_adr;
                bus.o_wb_dat   = bus.i_m1_dat;
                bus.o_wb_we    = bus.i_m1_we;
                bus.o_wb_sel   = bus.i_m1_sel;
                bus.o_wb_stb   = bus.i_m1_stb & ~tmo1;
                bus.o_wb_cyc   = bus.i_m1_cyc & ~tmo1;
                bus.o_m1_dat   = bus.i_wb_dat;
                bus.o_m1_ack   = bus.i_wb_ack;
                bus.o_m1_stall = bus.i_wb_stall;
                bus.o_m1_err   = tmo1;
                if (tmo1) begin
                    state_nx = IDLE;
                end else if (!bus.i_m1_cyc) begin
                    state_nx = req0 ? OWN0 : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Grant is decoded purely from the state register
    always_comb begin
        o_grant = {state == OWN1, state == OWN0};
    end

    // Timeout counter: restarts on any ownership entry (handover included),
    // on ack and whenever the bus goes idle
    always_comb begin
        if (state_nx == IDLE || state_nx != state || bus.i_wb_ack) begin
            tmo_cnt_nx = '0;
        end else if (bus.o_wb_cyc) begin
            tmo_cnt_nx = tmo_cnt + 16'd1;
        end else begin
            tmo_cnt_nx = tmo_cnt;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Timeout counter, lockout flags and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tmo_cnt <= '0;
            lock0   <= 1'b0;
            lock1   <= 1'b0;
            last_m1 <= 1'b1;
        end else begin
            tmo_cnt <= tmo_cnt_nx;
            if (tmo0) begin
                lock0 <= 1'b1;
            end else if (!bus.i_m0_cyc) begin
                lock0 <= 1'b0;
            end
            if (tmo1) begin
                lock1 <= 1'b1;
            end else if (!bus.i_m1_cyc) begin
                lock1 <= 1'b0;
            end
            if (state_nx == OWN0 && state != OWN0) begin
                last_m1 <= 1'b0;
            end else if (state_nx == OWN1 && state != OWN1) begin
                last_m1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with TIMEOUT_CYCLES = 4. Inputs change 1 ns
// after the rising edge; outputs are compared a further 1 ns later.
module tb_wb_arbiter2;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    int         n_cmp;
    int         n_bad;

    wb_arbiter2_if bus ();

    wb_arbiter2 #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave),
        .o_grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_m0_adr = '0; bus.i_m0_dat = '0; bus.i_m0_we = 1'b0; bus.i_m0_sel = '0;
        bus.i_m0_stb = 1'b0; bus.i_m0_cyc = 1'b0;
        bus.i_m1_adr = '0; bus.i_m1_dat = '0; bus.i_m1_we = 1'b0; bus.i_m1_sel = '0;
        bus.i_m1_stb = 1'b0; bus.i_m1_cyc = 1'b0;
        bus.i_wb_dat = '0; bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        settle();
        check_val("rst_grant", 64'(grant), 64'h0);
        check_val("rst_wb_cyc", 64'(bus.o_wb_cyc), 64'h0);
        check_val("rst_wb_stb", 64'(bus.o_wb_stb), 64'h0);
        check_val("rst_m0_stall", 64'(bus.o_m0_stall), 64'h1);
        check_val("rst_m1_stall", 64'(bus.o_m1_stall), 64'h1);
        check_val("rst_m0_ack", 64'(bus.o_m0_ack), 64'h0);
        check_val("rst_m1_err", 64'(bus.o_m1_err), 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Tie after reset goes to m0, zero-bubble handover, next tie to m0
        do_reset();
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_adr = 64'h1000;
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1; bus.i_m1_adr = 64'h2000;
        settle();
        check_val("tie_latency", 64'(grant), 64'h0);
        step();
        check_val("tie_first", 64'(grant), 64'h1);
        check_val("tie_adr", bus.o_wb_adr, 64'h1000);
        bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
        settle();
        check_val("ho_before", 64'(grant), 64'h1);
        step();
        check_val("ho_after", 64'(grant), 64'h2);
        check_val("ho_adr", bus.o_wb_adr, 64'h2000);
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        step();
        check_val("ho_idle", 64'(grant), 64'h0);
        bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
        step();
        check_val("tie_second", 64'(grant), 64'h1);
        bus.i_m0_cyc = 1'b0; bus.i_m1_cyc = 1'b0;
        step();
        check_val("tie_idle", 64'(grant), 64'h0);

        // Single m0 read with one-cycle ack
        do_reset();
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_adr = 64'h1000;
        bus.i_m0_sel = 8'hFF; bus.i_m0_dat = 64'hAA;
        step();
        check_val("rd_grant", 64'(grant), 64'h1);
        check_val("rd_wb_adr", bus.o_wb_adr, 64'h1000);
        check_val("rd_wb_sel", 64'(bus.o_wb_sel), 64'hFF);
        check_val("rd_wb_cyc", 64'(bus.o_wb_cyc), 64'h1);
        bus.i_wb_ack = 1'b1; bus.i_wb_dat = 64'h1234_5678_9ABC_DEF0;
        settle();
        check_val("rd_m0_ack", 64'(bus.o_m0_ack), 64'h1);
        check_val("rd_m0_dat", bus.o_m0_dat, 64'h1234_5678_9ABC_DEF0);
        check_val("rd_m1_dat", bus.o_m1_dat, 64'h0);
        check_val("rd_m1_ack", 64'(bus.o_m1_ack), 64'h0);
        check_val("rd_m1_stall", 64'(bus.o_m1_stall), 64'h1);
        step();
        bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0; bus.i_wb_ack = 1'b0;
        step();
        check_val("rd_idle", 64'(grant), 64'h0);
        check_val("rd_idle_cyc", 64'(bus.o_wb_cyc), 64'h0);

        // No preemption: m1 owns for 20 cycles while m0 requests
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1; bus.i_wb_ack = 1'b1;
        step();
        check_val("np_grant", 64'(grant), 64'h2);
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("np_hold", 64'(grant), 64'h2);
            check_val("np_m0_stall", 64'(bus.o_m0_stall), 64'h1);
            check_val("np_m0_ack", 64'(bus.o_m0_ack), 64'h0);
        end
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0; bus.i_wb_ack = 1'b0;
        step();
        check_val("np_handover", 64'(grant), 64'h1);
        bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0;
        step();
        check_val("np_idle", 64'(grant), 64'h0);

        // Timeout: four no-ack cycles, err in the fifth, lockout until cyc drops
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        step();
        check_val("to_grant", 64'(grant), 64'h2);
        for (int i = 0; i < 4; i++) begin
            check_val("to_noerr", 64'(bus.o_m1_err), 64'h0);
            check_val("to_cyc_on", 64'(bus.o_wb_cyc), 64'h1);
            step();
        end
        check_val("to_err", 64'(bus.o_m1_err), 64'h1);
        check_val("to_cyc_off", 64'(bus.o_wb_cyc), 64'h0);
        check_val("to_ack_off", 64'(bus.o_m1_ack), 64'h0);
        step();
        check_val("to_idle", 64'(grant), 64'h0);
        check_val("to_err_once", 64'(bus.o_m1_err), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("to_locked", 64'(grant), 64'h0);
        end
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        step();
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1;
        step();
        check_val("to_regrant", 64'(grant), 64'h2);

        // Ack on the 4th cycle, then ack exactly at the timeout point
        step();
        step();
        step();
        bus.i_wb_ack = 1'b1;
        settle();
        check_val("ack4_ack", 64'(bus.o_m1_ack), 64'h1);
        check_val("ack4_err", 64'(bus.o_m1_err), 64'h0);
        step();
        bus.i_wb_ack = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.i_wb_ack = 1'b1;
        settle();
        check_val("race_ack", 64'(bus.o_m1_ack), 64'h1);
        check_val("race_err", 64'(bus.o_m1_err), 64'h0);
        check_val("race_cyc", 64'(bus.o_wb_cyc), 64'h1);
        step();
        check_val("race_hold", 64'(grant), 64'h2);
        check_val("race_err_next", 64'(bus.o_m1_err), 64'h0);
        bus.i_wb_ack = 1'b0; bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0;
        step();
        check_val("race_idle", 64'(grant), 64'h0);

        // Reset mid-burst while m0 owns
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_wb_ack = 1'b1;
        step();
        check_val("mr_grant", 64'(grant), 64'h1);
        step();
        rst_n = 1'b0;
        step();
        check_val("mr_grant_off", 64'(grant), 64'h0);
        check_val("mr_cyc_off", 64'(bus.o_wb_cyc), 64'h0);
        check_val("mr_err", 64'(bus.o_m0_err), 64'h0);
        check_val("mr_stall", 64'(bus.o_m0_stall), 64'h1);
        check_val("mr_ack", 64'(bus.o_m0_ack), 64'h0);
        rst_n = 1'b1;
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
